// File: rtl/i2c_target_rx_if.sv
// i2c_target_rx_if
//  Avalon-MM register port plus interrupt line of the I2C write-target.
//  master : CPU / fabric side (drives address, strobes, writedata)
//  slave  : i2c_target_rx side (returns readdata, irq)
//  Signals: address[1:0], chipselect, read_n, write_n, writedata[7:0],
//           readdata[7:0] (zero wait state), irq (level)
interface i2c_target_rx_if;
    logic [1:0] address;
    logic       chipselect;
    logic       read_n;
    logic       write_n;
    logic [7:0] writedata;
    logic [7:0] readdata;
    logic       irq;

    modport master (
        output address, chipselect, read_n, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, read_n, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/i2c_target_rx.sv
// i2c_target_rx
//  Write-only I2C target. Samples SCL/SDA, detects START/STOP, matches a
//  7-bit address, ACKs by pulling SDA low and queues received bytes in a
//  small FIFO that the CPU drains over Avalon-MM. Level irq on data/overflow.
//  Ports:
//   clk, reset_n  system clock, async active-low reset
//   avl           Avalon-MM slave modport (regs: 0 DATA, 1 STATUS, 2 CTRL, 3 CLEAR)
//   scl_in/sda_in I2C pad inputs (asynchronous)
//   sda_oe        1 = pull SDA low (open-drain ACK)
module i2c_target_rx #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         FIFO_AW    = 2
) (
    input  logic           clk,
    input  logic           reset_n,
    i2c_target_rx_if.slave avl,
    input  logic           scl_in,
    input  logic           sda_in,
    output logic           sda_oe
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int CW    = FIFO_AW + 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ADDR   = 3'd1;
    localparam logic [2:0] S_ACK_A  = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_ACK_D  = 3'd4;
    localparam logic [2:0] S_IGNORE = 3'd5;

    // ---------------- pad sampling: [1:0] synchroniser, [2] previous value
    logic [2:0] scl_p, sda_p;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_p <= '0;
            sda_p <= '0;
        end else begin
            scl_p <= {scl_p[1:0], scl_in};
            sda_p <= {sda_p[1:0], sda_in};
        end
    end

    logic scl_rise, scl_fall, scl_hi, start_det, stop_det;
    assign scl_rise  =  scl_p[1] & ~scl_p[2];
    assign scl_fall  = ~scl_p[1] &  scl_p[2];
    // SCL must be high on both samples so an SDA edge racing an SCL edge
    // is not mistaken for START/STOP
    assign scl_hi    =  scl_p[1] &  scl_p[2];
    assign start_det = scl_hi &  sda_p[2] & ~sda_p[1];
    assign stop_det  = scl_hi & ~sda_p[2] &  sda_p[1];

    // ---------------- registers
    logic          enable, irq_en, overflow, stop_seen, irq_q;
    logic [2:0]    state, bit_cnt;
    logic [7:0]    shreg;
    logic          ack_drv, matched;
    logic [7:0]    mem [DEPTH];
    logic [FIFO_AW-1:0] wptr, rptr;
    logic [CW-1:0] count;

    logic [7:0] shift_byte;
    logic       full, not_empty, byte_done, push, pop, ovf_set, stop_set;
    logic       wr_en;

    assign shift_byte = {shreg[6:0], sda_p[1]};
    assign full       = (count == CW'(DEPTH));
    assign not_empty  = (count != '0);
    assign byte_done  = scl_rise & (bit_cnt == 3'd7);

    // START/STOP and disable take priority over in-byte events
    always_comb begin
        push     = 1'b0;
        ovf_set  = 1'b0;
        stop_set = 1'b0;
        if (enable && !start_det) begin
            if (stop_det) begin
                stop_set = matched;
            end else if (state == S_DATA && byte_done) begin
                push    = ~full;
                ovf_set =  full;
            end
        end
    end

    assign pop   = avl.chipselect & ~avl.read_n & (avl.address == 2'd0) & not_empty;
    assign wr_en = avl.chipselect & ~avl.write_n;

    // ---------------- FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            ack_drv <= 1'b0;
            matched <= 1'b0;
            sda_oe  <= 1'b0;
        end else if (!enable) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            ack_drv <= 1'b0;
            matched <= 1'b0;
            sda_oe  <= 1'b0;
        end else if (start_det) begin
            state   <= S_ADDR;
            bit_cnt <= '0;
            ack_drv <= 1'b0;
            sda_oe  <= 1'b0;
        end else if (stop_det) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            ack_drv <= 1'b0;
            matched <= 1'b0;
            sda_oe  <= 1'b0;
        end else begin
            case (state)
                S_ADDR, S_DATA: begin
                    if (scl_rise) begin
                        shreg   <= shift_byte;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (state == S_ADDR) begin
                                if (shift_byte[7:1] == SLAVE_ADDR && !shift_byte[0]) begin
                                    state   <= S_ACK_A;
                                    matched <= 1'b1;
                                end else begin
                                    state <= S_IGNORE;
                                end
                            end else begin
                                state <= full ? S_IGNORE : S_ACK_D;
                            end
                        end
                    end
                end
                // first SCL fall opens the ACK slot, second one closes it
                S_ACK_A, S_ACK_D: begin
                    if (scl_fall) begin
                        if (!ack_drv) begin
                            ack_drv <= 1'b1;
                            sda_oe  <= 1'b1;
                        end else begin
                            ack_drv <= 1'b0;
                            sda_oe  <= 1'b0;
                            bit_cnt <= '0;
                            state   <= S_DATA;
                        end
                    end
                end
                default: sda_oe <= 1'b0;
            endcase
        end
    end

    // ---------------- FIFO
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= shift_byte;
                wptr      <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ---------------- control / flags / irq
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable    <= 1'b0;
            irq_en    <= 1'b0;
            overflow  <= 1'b0;
            stop_seen <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            if (wr_en && avl.address == 2'd2) begin
                enable <= avl.writedata[0];
                irq_en <= avl.writedata[1];
            end
            // a clear racing a new event loses, so the event is never dropped
            if (wr_en && avl.address == 2'd3) begin
                if (avl.writedata[0]) overflow  <= 1'b0;
                if (avl.writedata[1]) stop_seen <= 1'b0;
            end
            if (ovf_set)  overflow  <= 1'b1;
            if (stop_set) stop_seen <= 1'b1;
            irq_q <= irq_en & (not_empty | overflow);
        end
    end

    assign avl.irq = irq_q;

    // ---------------- read mux (combinational, zero wait state)
    logic [7:0] rdata;
    always_comb begin
        rdata = 8'h00;
        case (avl.address)
            2'd0:    rdata = not_empty ? mem[rptr] : 8'h00;
            2'd1:    rdata = {4'(count), overflow, stop_seen, full, not_empty};
            2'd2:    rdata = {6'b0, irq_en, enable};
            default: rdata = 8'h00;
        endcase
    end
    assign avl.readdata = rdata;

    logic unused_wd;
    assign unused_wd = ^avl.writedata[7:2];
endmodule

// File: tb/tb_i2c_target_rx.sv
module tb_i2c_target_rx;
    localparam int Q = 8;   // system clocks per quarter I2C bit

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic scl = 1'b1;
    logic sda_drv = 1'b1;
    logic sda_oe;
    logic sda_line;
    assign sda_line = sda_drv & ~sda_oe;   // open-drain wired-AND

    always #5 clk = ~clk;

    i2c_target_rx_if bus();

    i2c_target_rx #(.SLAVE_ADDR(7'h50), .FIFO_AW(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .avl     (bus),
        .scl_in  (scl),
        .sda_in  (sda_line),
        .sda_oe  (sda_oe)
    );

    int n_chk = 0;
    int n_err = 0;

    // scoreboards and bench-side model
    logic       ack_q  [$];
    logic [7:0] exp_data [$];
    int         m_cnt  = 0;
    logic       m_ovf  = 1'b0;
    logic       m_stop = 1'b0;
    logic       m_irqen = 1'b0;
    logic [7:0] tx [8];
    int         rd_idx = -1;

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", tag, act, exp);
        end
    endtask

    task automatic wq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic avl_wr(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
    endtask

    task automatic avl_rd(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        bus.address = a; bus.chipselect = 1'b1; bus.read_n = 1'b0;
        #1 d = bus.readdata;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.read_n = 1'b1;
    endtask

    function automatic logic [7:0] m_status();
        return {4'(m_cnt), m_ovf, m_stop, (m_cnt == 4), (m_cnt != 0)};
    endfunction

    task automatic chk_status(input string tag);
        logic [7:0] v;
        avl_rd(2'd1, v);
        chk(tag, v, m_status());
    endtask

    task automatic chk_data(input string tag);
        logic [7:0] v, e;
        avl_rd(2'd0, v);
        if (exp_data.size() != 0) begin
            e = exp_data.pop_front();
            m_cnt--;
        end else begin
            e = 8'h00;
        end
        chk(tag, v, e);
    endtask

    task automatic i2c_start();
        sda_drv = 1'b1; wq();
        scl = 1'b1;     wq();
        sda_drv = 1'b0; wq();
        scl = 1'b0;     wq();
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0; wq();
        scl = 1'b1;     wq();
        sda_drv = 1'b1; wq();
    endtask

    task automatic send_bit(input logic b);
        sda_drv = b; wq();
        scl = 1'b1; repeat (2 * Q) @(negedge clk);
        scl = 1'b0; wq();
    endtask

    // rd: issue a DATA read timed to land on the push of this byte
    task automatic send_byte(input logic [7:0] b, input logic ea, input logic rd);
        logic [7:0] v;
        ack_q.push_back(ea);
        for (int i = 7; i >= 0; i--) begin
            sda_drv = b[i]; wq();
            scl = 1'b1;
            if (rd && i == 0) begin
                repeat (2) @(negedge clk);
                bus.address = 2'd0; bus.chipselect = 1'b1; bus.read_n = 1'b0;
                #1 v = bus.readdata;
                @(negedge clk);
                bus.chipselect = 1'b0; bus.read_n = 1'b1;
                chk("t5_pop", v, exp_data.pop_front());
                m_cnt--;
                repeat (2 * Q - 3) @(negedge clk);
            end else begin
                repeat (2 * Q) @(negedge clk);
            end
            scl = 1'b0; wq();
        end
        sda_drv = 1'b1; wq();
        scl = 1'b1; wq();
        chk("ack", 8'(sda_oe), 8'(ack_q.pop_front()));
        wq();
        scl = 1'b0; wq();
        chk("release", 8'(sda_oe), 8'h00);
    endtask

    task automatic i2c_write(input logic [7:0] ab, input int n);
        logic m_match, ign, ack;
        m_match = (ab[7:1] == 7'h50) && !ab[0];
        ign = !m_match;
        i2c_start();
        send_byte(ab, m_match, 1'b0);
        for (int i = 0; i < n; i++) begin
            ack = !ign && (m_cnt < 4);
            if (!ign && m_cnt >= 4) begin
                m_ovf = 1'b1;
                ign = 1'b1;
            end
            if (ack) begin
                exp_data.push_back(tx[i]);
                m_cnt++;
            end
            send_byte(tx[i], ack, (i == rd_idx));
        end
        i2c_stop();
        if (m_match) m_stop = 1'b1;
    endtask

    initial begin
        logic [7:0] v;
        bus.address = 2'd0; bus.chipselect = 1'b0; bus.read_n = 1'b1;
        bus.write_n = 1'b1; bus.writedata = 8'h00;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_sda_oe", 8'(sda_oe), 8'h00);
        chk("rst_irq", 8'(bus.irq), 8'h00);
        reset_n = 1'b1;
        chk_status("rst_status");
        avl_rd(2'd2, v); chk("rst_ctrl", v, 8'h00);
        chk_data("rst_data_empty");

        avl_wr(2'd2, 8'h01);
        avl_rd(2'd2, v); chk("ctrl_en", v, 8'h01);

        // T1: two bytes to 0x50
        tx[0] = 8'hA5; tx[1] = 8'h3C;
        i2c_write(8'hA0, 2);
        chk_status("t1_status");
        chk("t1_status_lit", m_status(), 8'h25);
        chk("t1_irq_off", 8'(bus.irq), 8'h00);
        chk_data("t1_d0");
        chk_data("t1_d1");
        chk_status("t1_status_after");
        avl_wr(2'd3, 8'h02); m_stop = 1'b0;
        chk_status("t1_stop_clr");

        // T2: address 0x51, ignored
        tx[0] = 8'h77;
        i2c_write(8'hA2, 1);
        chk_status("t2_status");

        // T3: five bytes into depth 4
        avl_wr(2'd2, 8'h03); m_irqen = 1'b1;
        tx[0] = 8'h01; tx[1] = 8'h02; tx[2] = 8'h03; tx[3] = 8'h04; tx[4] = 8'h05;
        i2c_write(8'hA0, 5);
        chk_status("t3_status");
        repeat (2) @(negedge clk);
        chk("t3_irq", 8'(bus.irq), 8'(m_irqen & (m_cnt != 0 || m_ovf)));
        avl_wr(2'd3, 8'h01); m_ovf = 1'b0;
        chk_status("t3_ovf_clr");
        for (int i = 0; i < 4; i++) chk_data("t3_drain");
        repeat (2) @(negedge clk);
        chk("t3_irq_idle", 8'(bus.irq), 8'(m_irqen & (m_cnt != 0 || m_ovf)));
        avl_wr(2'd3, 8'h02); m_stop = 1'b0;

        // T4: repeated START after 3 data bits
        i2c_start();
        send_byte(8'hA0, 1'b1, 1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        tx[0] = 8'h11;
        i2c_write(8'hA0, 1);
        chk_status("t4_status");
        chk_data("t4_d0");
        chk_data("t4_empty");
        avl_wr(2'd3, 8'h02); m_stop = 1'b0;

        // T5: DATA read coinciding with a push at count 2
        tx[0] = 8'hC1; tx[1] = 8'hC2; tx[2] = 8'hC3;
        rd_idx = 2;
        i2c_write(8'hA0, 3);
        rd_idx = -1;
        chk_status("t5_status");
        chk_data("t5_d1");
        chk_data("t5_d2");
        avl_wr(2'd3, 8'h02); m_stop = 1'b0;

        // T6: async reset during address ACK
        tx[0] = 8'h99;
        i2c_write(8'hA0, 1);
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(v[0] ^ v[0] ^ ((8'hA0 >> i) & 8'h01) != 0);
        sda_drv = 1'b1; wq();
        scl = 1'b1; wq();
        chk("t6_ack_on", 8'(sda_oe), 8'h01);
        reset_n = 1'b0;
        #1 chk("t6_sda_rel", 8'(sda_oe), 8'h00);
        exp_data.delete(); m_cnt = 0; m_ovf = 1'b0; m_stop = 1'b0;
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        chk_status("t6_status");
        avl_rd(2'd2, v); chk("t6_ctrl", v, 8'h00);
        chk_data("t6_empty");
        chk("t6_irq", 8'(bus.irq), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    // hard time bound so the run always ends
    initial begin
        #2ms;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
